// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// mul_div_unit : multi-cycle MIPS-style multiply/divide unit owning HI/LO.
// Optional macro FAST_MUL_EN selects a single-cycle combinational multiplier.
// Revision 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [4:0]       ALUCtrl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d, srca_q, srca_d;
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

    logic             w_is_mul, w_is_div, w_op_valid, w_op_stall;
    logic             w_sign_a, w_sign_b, w_idle_like, w_busy;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;

    assign w_is_mul    = (ALUCtrl[4:1] == 4'b0100);
    assign w_is_div    = (ALUCtrl[4:1] == 4'b0011);
    assign w_op_valid  = start & (w_is_mul | w_is_div) & ~flush;
    assign w_sign_a    = ~ALUCtrl[0] & SrcA[WIDTH-1];
    assign w_sign_b    = ~ALUCtrl[0] & SrcB[WIDTH-1];
    assign w_mag_a     = w_sign_a ? (~SrcA + WIDTH'(1)) : SrcA;
    assign w_mag_b     = w_sign_b ? (~SrcB + WIDTH'(1)) : SrcB;
    assign w_idle_like = (state_q == IDLE) | (state_q == DONE);
    assign w_busy      = (state_q == MUL) | (state_q == DIV);

    // Shift-add step: acc_hi holds the running partial sum, acc_lo the multiplier.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
    logic [PW-1:0]    w_mul_prod, w_mul_fin;

    assign w_mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_hi   = w_mul_sum[WIDTH:1];
    assign w_mul_lo   = {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};
    assign w_mul_prod = {w_mul_hi, w_mul_lo};
    assign w_mul_fin  = neg_res_q ? (~w_mul_prod + PW'(1)) : w_mul_prod;

    // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_sub, w_div_rem, w_div_quo, w_quo_fin, w_rem_fin;
    logic             w_div_ge;

    assign w_div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - opnd_q;
    assign w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {acc_lo_q[WIDTH-2:0], w_div_ge};
    assign w_quo_fin   = dz_q ? '1 :
                         (neg_res_q ? (~w_div_quo + WIDTH'(1)) : w_div_quo);
    assign w_rem_fin   = dz_q ? srca_q :
                         (neg_rem_q ? (~w_div_rem + WIDTH'(1)) : w_div_rem);

`ifdef FAST_MUL_EN
    logic [PW-1:0] w_fast_prod, w_fast_fin;

    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
    assign w_fast_fin  = (w_sign_a ^ w_sign_b) ? (~w_fast_prod + PW'(1)) : w_fast_prod;
    assign w_op_stall  = w_op_valid & w_is_div;
`else
    assign w_op_stall  = w_op_valid;
`endif

    assign stall = ~flush & ((w_op_stall & w_idle_like) | w_busy);
    assign done  = ~flush & (state_q == DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        srca_d    = srca_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                state_d = IDLE;
                if (w_op_valid) begin
                    cnt_d     = '0;
                    srca_d    = SrcA;
                    neg_res_d = w_sign_a ^ w_sign_b;
                    neg_rem_d = w_sign_a;
                    dz_d      = w_is_div & (SrcB == '0);
                    acc_hi_d  = '0;
                    if (w_is_mul) begin
`ifdef FAST_MUL_EN
                        hi_d    = w_fast_fin[PW-1:WIDTH];
                        lo_d    = w_fast_fin[WIDTH-1:0];
                        state_d = DONE;
`else
                        acc_lo_d = w_mag_b;
                        opnd_d   = w_mag_a;
                        state_d  = MUL;
`endif
                    end else begin
                        acc_lo_d = w_mag_a;
                        opnd_d   = w_mag_b;
                        state_d  = DIV;
                    end
                end
            end
            MUL: begin
                cnt_d    = cnt_q + CNT_W'(1);
                acc_hi_d = w_mul_hi;
                acc_lo_d = w_mul_lo;
                if (cnt_q == LAST_CNT) begin
                    hi_d    = w_mul_fin[PW-1:WIDTH];
                    lo_d    = w_mul_fin[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            default: begin
                cnt_d    = cnt_q + CNT_W'(1);
                acc_hi_d = w_div_rem;
                acc_lo_d = w_div_quo;
                if (cnt_q == LAST_CNT) begin
                    hi_d    = w_rem_fin;
                    lo_d    = w_quo_fin;
                    state_d = DONE;
                end
            end
        endcase
        // A flush squashes any in-flight op and any HI/LO write of this cycle.
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            srca_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            srca_q    <= srca_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mul_div_unit : directed-vector bench for mul_div_unit (default build).
// Revision 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn, start, flush, hi_we, lo_we;
    logic [4:0]   ALUCtrl;
    logic [W-1:0] SrcA, SrcB, wdata;
    logic         stall, done;
    logic [W-1:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .ALUCtrl (ALUCtrl),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Drives an op in cycle 0 and checks the stall asserts immediately.
    task automatic issue(input string tag, input logic [4:0] ctrl, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        @(posedge clk); #1;
        start = 1'b1; ALUCtrl = ctrl; SrcA = a; SrcB = b;
        @(negedge clk);
        check_val({tag, "_stall_c0"}, 64'(stall), 64'd1);
    endtask

    task automatic wait_done(input logic hold_en, input logic [W-1:0] hold_val,
                             output int n_stall, output int done_at, output int hold_bad);
        n_stall  = 0;
        done_at  = -1;
        hold_bad = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0; ALUCtrl = '0; hi_we = 1'b0; lo_we = 1'b0;
            @(negedge clk);
            if (stall) n_stall++;
            if (done) begin
                done_at = cyc;
                break;
            end
            if (hold_en && (hi !== hold_val)) hold_bad++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int ns, da, hb;
        issue(tag, ctrl, a, b);
        wait_done(1'b0, '0, ns, da, hb);
        check_val({tag, "_stall_cycles"}, 64'(ns), 64'd32);
        check_val({tag, "_done_cycle"}, 64'(da), 64'd33);
        check_val({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check_val({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0; ALUCtrl = '0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            @(negedge clk);
            if (done || stall) seen++;
        end
        check_val(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int ns, da, hb, bad;
        resetn = 1'b0; start = 1'b0; ALUCtrl = '0; SrcA = '0; SrcB = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op("multu_max", 5'b01001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 5'b01000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div_m7_2", 5'b00110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // divu 100/7, then mthi + mult -3*4 presented in its DONE cycle
        issue("divu_b2b", 5'b00111, 32'd100, 32'd7);
        repeat (32) begin
            @(posedge clk); #1;
            start = 1'b0; ALUCtrl = '0;
        end
        @(posedge clk); #1;
        start = 1'b1; ALUCtrl = 5'b01000; SrcA = 32'hFFFF_FFFD; SrcB = 32'd4;
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        check_val("divu_done", 64'(done), 64'd1);
        check_val("divu_hi", 64'(hi), 64'd2);
        check_val("divu_lo", 64'(lo), 64'd14);
        check_val("b2b_stall_c0", 64'(stall), 64'd1);
        wait_done(1'b1, 32'hA5A5_A5A5, ns, da, hb);
        check_val("b2b_hi_hold", 64'(hb), 64'd0);
        check_val("b2b_stall_cycles", 64'(ns), 64'd32);
        check_val("b2b_done_cycle", 64'(da), 64'd33);
        check_val("b2b_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check_val("b2b_lo", 64'(lo), 64'h0000_0000_FFFF_FFF4);

        run_op("div_by_zero", 5'b00110, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_ovf", 5'b00110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // mthi / mtlo while idle
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'h600D_CAFE;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        check_val("mthi_hi", 64'(hi), 64'h0000_0000_600D_CAFE);
        check_val("mthi_lo_keep", 64'(lo), 64'h0000_0000_8000_0000);
        @(posedge clk); #1;
        lo_we = 1'b0;
        @(negedge clk);
        check_val("mtlo_lo", 64'(lo), 64'h0000_0000_0BAD_F00D);

        // non-mul/div code has no effect
        @(posedge clk); #1;
        start = 1'b1; ALUCtrl = 5'b00100; SrcA = 32'd5; SrcB = 32'd6;
        @(negedge clk);
        check_val("nop_stall", 64'(stall), 64'd0);
        expect_quiet("nop_quiet", 40);
        check_val("nop_hi", 64'(hi), 64'h0000_0000_600D_CAFE);

        // flush in cycle 10 of mult 5*6
        issue("mult_flush", 5'b01000, 32'd5, 32'd6);
        bad = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0; ALUCtrl = '0;
            @(negedge clk);
            if (!stall) bad++;
        end
        check_val("flush_pre_stall", 64'(bad), 64'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check_val("flush_stall", 64'(stall), 64'd0);
        check_val("flush_done", 64'(done), 64'd0);
        expect_quiet("flush_quiet", 40);
        check_val("flush_hi", 64'(hi), 64'h0000_0000_600D_CAFE);
        check_val("flush_lo", 64'(lo), 64'h0000_0000_0BAD_F00D);

        // async reset mid-divide
        issue("div_reset", 5'b00110, 32'h1234_5678, 32'd3);
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0; ALUCtrl = '0;
        end
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check_val("mid_rst_hi", 64'(hi), 64'd0);
        check_val("mid_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        check_val("mid_rst_stall", 64'(stall), 64'd0);
        check_val("mid_rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        expect_quiet("post_rst_quiet", 40);

        run_op("divu_after_rst", 5'b00111, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage multi-cycle multiply/divide unit; downstream consumer of ALUCtrl from the ALU decoder.
- Handles ALUCtrl[4:1]=4'b0100 (mult/multu) and 4'b0011 (div/divu); ALUCtrl[0] selects signed (0) or unsigned (1).
- Owns architectural HI/LO registers; serves mthi/mtlo writes.
- Drives a stall to the pipeline hazard unit while iterating.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  execute-stage instruction valid this cycle
ALUCtrl  in  5  decoded ALU control; only 0011_x and 0100_x act here
SrcA  in  WIDTH  rs value; dividend / multiplicand
SrcB  in  WIDTH  rt value; divisor / multiplier
flush  in  1  pipeline flush (exception/eret); aborts in-flight op
hi_we  in  1  mthi write enable
lo_we  in  1  mtlo write enable
wdata  in  WIDTH  mthi/mtlo data
stall  out  1  hold execute stage and all earlier stages
done  out  1  one-cycle pulse: HI/LO just updated by mul/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, resetn=0): state IDLE, hi=0, lo=0, done=0, counter=0; stall=0 while start=0.
- op_valid = start & (ALUCtrl[4:1]==4'b0011 | ALUCtrl[4:1]==4'b0100) & ~flush.
- States: IDLE, MUL, DIV, DONE.
- IDLE: op_valid -> latch operands and sign info, counter=0; go to MUL or DIV.
- MUL/DIV: one iteration per cycle; counter increments.
  - At counter==WIDTH-1: write HI/LO and go to DONE.
- DONE: done=1 for exactly one cycle. Next state IDLE, or MUL/DIV directly if op_valid (back-to-back ops).
- stall (combinational) = (op_valid & state in {IDLE,DONE}) | state in {MUL,DIV}.
- Latency: start in cycle 0; stall high cycles 0..WIDTH (33 cycles at WIDTH=32); HI/LO visible and done=1 in cycle WIDTH+1.
- Multiply: shift-add on magnitudes, 2*WIDTH-bit product; hi=product[2W-1:W], lo=product[W-1:0].
  - Signed: operand magnitudes taken up front; product negated if operand signs differ.
- Divide: restoring algorithm on magnitudes; lo=quotient, hi=remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 signed: lo=0x80000000, hi=0.
- Divide by zero: same latency; lo=32'hFFFF_FFFF, hi=SrcA as latched; no exception.
- start while MUL/DIV: ignored; the stall guarantees the pipeline re-presents it.
- flush: any state -> IDLE next edge; HI/LO unchanged; done=0; stall drops the same cycle via ~flush and the state change.
- hi_we/lo_we: write wdata to HI/LO at the clock edge in IDLE/DONE only.
  - Ignored in MUL/DIV; the pipeline is stalled then, so no write is presented.
  - Same cycle as op_valid: the write applies, and the op's result later overwrites HI/LO.
- Non-mul/div ALUCtrl codes: no effect.

Optional Feature:
FAST_MUL_EN
- Defined: multiply uses a single-cycle combinational WIDTH x WIDTH product.
  - op_valid mul in IDLE/DONE writes HI/LO at the end of cycle 0; DONE in cycle 1.
  - stall never asserted for mul. Divide unchanged.
- Undefined: iterative shift-add multiply as above; no hardware multiplier inferred.

Test Plan:
- Reset: hold resetn=0 mid-DIV, then release -> hi=0, lo=0, done=0, stall=0, state IDLE.
- multu 0xFFFFFFFF*0xFFFFFFFF (ALUCtrl=01001) -> stall high 33 cycles; cycle 33 done=1, hi=0xFFFFFFFE, lo=0x00000001. With FAST_MUL_EN: done in cycle 1, stall never high.
- div -7/2 (ALUCtrl=00110) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 100/7 -> lo=14, hi=2.
- div 0x12345678/0 -> after 33 stall cycles lo=0xFFFFFFFF, hi=0x12345678.
- mult 5*6, flush at cycle 10 -> stall=0 at cycle 10, IDLE next; HI/LO keep prior values; done never pulses.
- mthi 0xA5A5A5A5 then back-to-back mult -3*4 issued in the DONE cycle of a prior op -> hi=0xA5A5A5A5 until completion, then hi=0xFFFFFFFF, lo=0xFFFFFFF4.
